detect_merge: RTL

Parametrised in-order merger of detection results from `N_LANES` parallel classifier lanes. It sits between the data fetcher's window-position stream and the system's detected-address/interrupt outputs, and replaces the single-lane position/result pairing with a round-robin, multi-lane pairing. It buffers window positions and reorders nothing: lanes are serviced strictly round-robin, matching the dispatch order upstream. It emits packed detection words, signals end of frame via an eot word plus interrupt, and pulses a frame reset once the frame is fully drained.

---
 rtl/detect_merge_if.sv | 69 ++++++
 rtl/detect_merge.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/detect_merge_if.sv
`default_nettype none
// ============================================================================
// Module      : detect_merge_if
// Description : Bundle of the window-position, lane-result, detected-address,
//               interrupt and frame-reset signals of detect_merge.
//               slave  : view of detect_merge itself.
//               master : view of the surrounding pipeline / environment.
// Ports       : window_pos_*   position stream (valid/ready/eot/scale/y/x)
//               result_*       per-lane classifier results (valid/ready/bit)
//               detected_addr_* packed detection words out (valid/ready/data)
//               interrupt_*    end-of-frame interrupt (valid/ready/data)
//               frame_rst      one-cycle end-of-frame reset pulse
// Revision    : 1.0 - initial release
// ============================================================================
interface detect_merge_if #(
    parameter int N_LANES = 4,
    parameter int W_X     = 9,
    parameter int W_Y     = 9,
    parameter int W_SCALE = 3,
    parameter int W_OUT   = 25
);
    logic               window_pos_valid;
    logic               window_pos_ready;
    logic               window_pos_eot;
    logic [W_SCALE-1:0] window_pos_scale;
    logic [W_Y-1:0]     window_pos_y;
    logic [W_X-1:0]     window_pos_x;

    logic [N_LANES-1:0] result_valid;
    logic [N_LANES-1:0] result_ready;
    logic [N_LANES-1:0] result;

    logic               detected_addr_valid;
    logic               detected_addr_ready;
    logic [W_OUT-1:0]   detected_addr_data;

    logic               interrupt_valid;
    logic               interrupt_ready;
    logic               interrupt_data;

    logic               frame_rst;

    modport slave (
        input  window_pos_valid, window_pos_eot, window_pos_scale,
               window_pos_y, window_pos_x,
        output window_pos_ready,
        input  result_valid, result,
        output result_ready,
        output detected_addr_valid, detected_addr_data,
        input  detected_addr_ready,
        output interrupt_valid, interrupt_data,
        input  interrupt_ready,
        output frame_rst
    );

    modport master (
        output window_pos_valid, window_pos_eot, window_pos_scale,
               window_pos_y, window_pos_x,
        input  window_pos_ready,
        output result_valid, result,
        input  result_ready,
        input  detected_addr_valid, detected_addr_data,
        output detected_addr_ready,
        input  interrupt_valid, interrupt_data,
        output interrupt_ready,
        input  frame_rst
    );
endinterface
`default_nettype wire

// File: rtl/detect_merge.sv
`default_nettype none
// ============================================================================
// Module      : detect_merge
// Description : In-order merger of detection results from N_LANES classifier
//               lanes. Window positions are buffered and paired strictly
//               round-robin with lane results; positive results produce
//               packed detection words, the last window of a frame adds an
//               eot word (filler all ones) that also raises the interrupt.
//               Once the eot word is consumed a one-cycle frame_rst is issued
//               and all internal state is cleared for the next frame.
// Ports       : clk  - clock
//               rst  - asynchronous active-high reset
//               bus  - detect_merge_if.slave (positions, lane results,
//                      detected-address words, interrupt, frame_rst)
// Revision    : 1.0 - initial release
// ============================================================================
module detect_merge #(
    parameter int N_LANES   = 4,
    parameter int POS_DEPTH = 8,
    parameter int OUT_DEPTH = 4,
    parameter int W_X       = 9,
    parameter int W_Y       = 9,
    parameter int W_SCALE   = 3,
    parameter int W_OUT     = 25
) (
    input  logic          clk,
    input  logic          rst,
    detect_merge_if.slave bus
);
    localparam int c_fill_w = W_OUT - W_SCALE - W_Y - W_X;
    localparam int c_pos_w  = 1 + W_SCALE + W_Y + W_X;
    localparam int c_pa_w   = $clog2(POS_DEPTH);
    localparam int c_oa_w   = $clog2(OUT_DEPTH);
    localparam int c_lane_w = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(N_LANES - 1);
    localparam logic [c_lane_w-1:0] c_lane_one  = c_lane_w'(1);
    localparam logic [N_LANES-1:0]  c_lane_bit0 = N_LANES'(1);
    localparam logic [c_pa_w:0]     c_pos_one   = (c_pa_w + 1)'(1);
    localparam logic [c_oa_w:0]     c_out_one   = (c_oa_w + 1)'(1);
    localparam logic [c_oa_w-1:0]   c_slot_one  = c_oa_w'(1);
    localparam logic [c_oa_w+1:0]   c_out_depth = (c_oa_w + 2)'(OUT_DEPTH);

    generate
        if (c_fill_w < 1) begin : g_bad_width
            $error("detect_merge: W_OUT leaves no filler bit above {scale, y, x}");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_active;   // holds window_pos_ready low until the first clock after reset
    logic [c_lane_w-1:0] r_rd_lane;

    // Position FIFO: {eot, scale, y, x}, pointers carry one wrap bit.
    logic [c_pos_w-1:0] r_pos_mem [POS_DEPTH];
    logic [c_pa_w:0]    r_pos_wr;
    logic [c_pa_w:0]    r_pos_rd;

    // Output FIFO: first-word fall-through, eot words carry all-ones filler.
    logic [W_OUT-1:0]   r_out_mem [OUT_DEPTH];
    logic [c_oa_w:0]    r_out_wr;
    logic [c_oa_w:0]    r_out_rd;

    logic                   w_pos_empty;
    logic                   w_pos_full;
    logic                   w_pos_push;
    logic [c_pos_w-1:0]     w_pos_head;
    logic                   w_win_eot;
    logic [c_pos_w-2:0]     w_win_syx;
    logic [c_oa_w:0]        w_out_count;
    logic                   w_out_empty;
    logic [W_OUT-1:0]       w_out_head;
    logic                   w_head_eot;
    logic                   w_out_pop;
    logic [c_oa_w+1:0]      w_room;
    logic [1:0]             w_need;
    logic                   w_lane_valid;
    logic                   w_lane_res;
    logic                   w_fire;
    logic                   w_push_det;
    logic                   w_push_eot;
    logic [c_oa_w:0]        w_push_n;
    logic [c_oa_w-1:0]      w_slot0;
    logic [c_oa_w-1:0]      w_slot1;

    assign w_pos_empty = (r_pos_wr == r_pos_rd);
    assign w_pos_full  = (r_pos_wr[c_pa_w] != r_pos_rd[c_pa_w]) &&
                         (r_pos_wr[c_pa_w-1:0] == r_pos_rd[c_pa_w-1:0]);
    assign w_pos_head  = r_pos_mem[r_pos_rd[c_pa_w-1:0]];
    assign w_win_eot   = w_pos_head[c_pos_w-1];
    assign w_win_syx   = w_pos_head[c_pos_w-2:0];

    assign w_out_count = r_out_wr - r_out_rd;
    assign w_out_empty = (w_out_count == '0);
    assign w_out_head  = r_out_mem[r_out_rd[c_oa_w-1:0]];
    // Filler MSB is 0 in detection words and 1 in eot words.
    assign w_head_eot  = w_out_head[W_OUT-1];
    // The eot word needs both handshakes in the same cycle.
    assign w_out_pop   = !w_out_empty && bus.detected_addr_ready &&
                         (!w_head_eot || bus.interrupt_ready);

    assign w_lane_valid = bus.result_valid[r_rd_lane];
    assign w_lane_res   = bus.result[r_rd_lane];

    // Free slots counting this cycle's pop; slots needed = result + eot.
    assign w_room = c_out_depth - {1'b0, w_out_count} + {{(c_oa_w+1){1'b0}}, w_out_pop};
    assign w_need = {1'b0, w_lane_res} + {1'b0, w_win_eot};

    assign w_fire = (r_state == ST_RUN) && !w_pos_empty && w_lane_valid &&
                    (w_room >= {{c_oa_w{1'b0}}, w_need});

    assign w_push_det = w_fire && w_lane_res;
    assign w_push_eot = w_fire && w_win_eot;
    assign w_push_n   = {{c_oa_w{1'b0}}, w_push_det} + {{c_oa_w{1'b0}}, w_push_eot};
    assign w_slot0    = r_out_wr[c_oa_w-1:0];
    assign w_slot1    = w_slot0 + c_slot_one;

    assign w_pos_push = bus.window_pos_valid && bus.window_pos_ready;

    assign bus.window_pos_ready    = r_active && (r_state == ST_RUN) && !w_pos_full;
    assign bus.result_ready        = w_fire ? (c_lane_bit0 << r_rd_lane) : '0;
    assign bus.detected_addr_valid = !w_out_empty;
    assign bus.detected_addr_data  = w_out_empty ? '0 : w_out_head;
    assign bus.interrupt_valid     = !w_out_empty && w_head_eot;
    assign bus.interrupt_data      = !w_out_empty && w_head_eot;
    assign bus.frame_rst           = (r_state == ST_FLUSH);

    // Storage arrays carry no reset; validity is defined by the pointers.
    always_ff @(posedge clk) begin
        if (w_pos_push) begin
            r_pos_mem[r_pos_wr[c_pa_w-1:0]] <= {bus.window_pos_eot, bus.window_pos_scale,
                                                bus.window_pos_y, bus.window_pos_x};
        end
        if (w_push_det) begin
            r_out_mem[w_slot0] <= {{c_fill_w{1'b0}}, w_win_syx};
        end
        if (w_push_eot) begin
            r_out_mem[w_push_det ? w_slot1 : w_slot0] <= {{c_fill_w{1'b1}}, w_win_syx};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_active  <= 1'b0;
            r_rd_lane <= '0;
            r_pos_wr  <= '0;
            r_pos_rd  <= '0;
            r_out_wr  <= '0;
            r_out_rd  <= '0;
        end else begin
            r_active <= 1'b1;
            case (r_state)
                ST_RUN:   if (w_fire && w_win_eot)     r_state <= ST_DRAIN;
                ST_DRAIN: if (w_out_pop && w_head_eot) r_state <= ST_FLUSH;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase

            if (r_state == ST_FLUSH) begin
                // Positions queued behind the eot window belong to the
                // aborted tail of the frame and are dropped with everything else.
                r_rd_lane <= '0;
                r_pos_wr  <= '0;
                r_pos_rd  <= '0;
                r_out_wr  <= '0;
                r_out_rd  <= '0;
            end else begin
                if (w_pos_push) r_pos_wr <= r_pos_wr + c_pos_one;
                if (w_fire) begin
                    r_pos_rd  <= r_pos_rd + c_pos_one;
                    r_rd_lane <= (r_rd_lane == c_last_lane) ? '0 : r_rd_lane + c_lane_one;
                end
                r_out_wr <= r_out_wr + w_push_n;
                if (w_out_pop) r_out_rd <= r_out_rd + c_out_one;
            end
        end
    end
endmodule
`default_nettype wire
